fetch_queue: RTL
================

# fetch_queue

Instruction fetch front end for the VLIW core. It generates the fetch PC, issues requests to the synchronous instruction memory, and buffers the returned bundles in a small FIFO. It presents them in order to decode. It sits directly upstream of decode and consumes the redirect produced by the branch/jump resolver (`npc_enn` plus target), discarding all wrong-path bundles on a redirect.

## Interface
- `PC_W`, 15: width of the bundle address (PC counts bundles, +1 per bundle).
- `INST_W`, 64: width of one fetched bundle.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 0: first address fetched after reset.

- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode cannot accept the head bundle this cycle.
- `npc_enn`  in  1  redirect: a taken branch/jump was resolved this cycle.
- `jump_target`  in  PC_W  redirect address, valid when `npc_enn`=1.
- `imem_en`  out  1  read request this cycle (combinational).
- `imem_addr`  out  PC_W  read address (combinational).
- `imem_rdata`  in  INST_W  data for the request issued in the previous cycle (fixed 1-cycle latency).
- `if_valid`  out  1  head entry valid.
- `if_pc`  out  PC_W  PC of head entry.
- `if_inst`  out  INST_W  bundle of head entry.

## Operation
- State: `fetch_pc_q`, `inflight_q` (1 bit), `resp_pc_q`, FIFO storage of {pc, inst} × DEPTH, `rd_ptr`, `wr_ptr`, `count_q` (0..DEPTH).
- Per-cycle decisions:
  - `pop` = `if_valid` & ~`stall` & ~`npc_enn`.
  - `wr` = `inflight_q` & ~`npc_enn`; writes {`resp_pc_q`, `imem_rdata`} at `wr_ptr`.
  - `issue` = `npc_enn` | (`count_q` + `inflight_q` < DEPTH). This credit check guarantees `wr` never targets a full FIFO.
  - `imem_en` = `issue`; `imem_addr` = `npc_enn` ? `jump_target` : `fetch_pc_q`.
- Clock edge:
  - If `issue`: `fetch_pc_q` ← `imem_addr`+1 and `resp_pc_q` ← `imem_addr`.
  - `inflight_q` ← `issue`.
  - If `npc_enn`: `count_q` ← 0 and `rd_ptr` = `wr_ptr` ← 0. Otherwise `count_q` ← `count_q` + `wr` − `pop`, with the pointers advanced mod DEPTH on `wr`/`pop`.
- Redirect (`npc_enn`=1):
  - Flushes all queued entries.
  - Discards the response arriving in that cycle.
  - Issues a request at `jump_target` in the same cycle.
  - Takes priority over `stall` and over full-queue backpressure.
- Simultaneous `wr` and `pop` on a full or empty queue is legal; `count_q` is unchanged.
- `if_valid` = (`count_q` ≠ 0). `if_pc`/`if_inst` show the entry at `rd_ptr` and are held stable while `stall`=1.
- PC arithmetic is unsigned modulo 2^PC_W: `fetch_pc_q` = 2^PC_W−1 wraps to 0.

## Timing
- Reset (async, any time):
  - Values: `fetch_pc_q`=RESET_PC, `inflight_q`=0, `count_q`=0, pointers 0, storage 0, `resp_pc_q`=0.
  - Outputs: `if_valid`=0, `if_pc`=0, `if_inst`=0. `imem_en`=1 and `imem_addr`=RESET_PC combinationally.
  - Reset mid-operation drops all in-flight state with no partial writes.
- First edge after `rstn` rises captures the RESET_PC request. The RESET_PC bundle is written at the second edge, so `if_valid`=1 in the 2nd cycle after release.
- Steady state with `stall`=0: one bundle per cycle, consecutive PCs, no bubbles. Fetch-to-head latency is 2 cycles.
- `stall` held: the queue fills to DEPTH, then `imem_en`=0 until a pop frees credit. There are no duplicates or gaps on resume.
- `npc_enn` in cycle T:
  - `if_valid`=0 in T+1.
  - Target bundle at head in T+2 with `if_pc`=`jump_target`.
  - No pre-redirect PC is ever presented after T.
- `npc_enn` in T+1 again (redirect during the bubble) supersedes the first target under the same rule.

## Test plan
- Reset with RESET_PC=0, `stall`=0, and a memory model where rdata = 0xA000_0000+addr -> `if_valid` rises 2 cycles after release; `if_pc` = 0,1,2,3… one per cycle with matching `if_inst`.
- `stall`=1 for 8 cycles from head pc=5 -> head stays pc 5; `count_q` reaches 4; `imem_en`=0 once credit is exhausted; after release pcs 5,6,7,8,9 with no gaps or duplicates.
- Queue holding pcs 10–12 with one request in flight, then `npc_enn`=1 and `jump_target`=0x100 at T -> `if_valid`=0 at T+1; T+2 `if_pc`=0x100; then 0x101, 0x102; pcs 10–13 never appear.
- `npc_enn`=1 with `stall`=1 and the queue full -> request at target is issued in the same cycle; the flush behaves identically to the previous case.
- `jump_target`=0x7FFF (PC_W=15) -> `if_pc` sequence 0x7FFF, 0x0000, 0x0001.
- `rstn` pulsed low for one cycle while the queue holds 3 entries and a request is in flight -> `if_valid`=0 immediately (async); refetch restarts at RESET_PC with the 2-cycle latency.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC generation, 1-cycle synchronous imem requests and an
// in-order bundle FIFO feeding decode, flushed and re-steered by branch/jump redirects.
module fetch_queue #(
  parameter int unsigned     PC_W     = 15,
  parameter int unsigned     INST_W   = 64,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              npc_enn,
  input  logic [PC_W-1:0]   jump_target,
  output logic              imem_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [PC_W-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]                r_fetch_pc;
  logic [PC_W-1:0]                r_resp_pc;
  logic                           r_inflight;
  logic [DEPTH-1:0][PC_W-1:0]     r_mem_pc;
  logic [DEPTH-1:0][INST_W-1:0]   r_mem_inst;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [CNT_W-1:0]               r_count;

  logic                           w_pop;
  logic                           w_wr;
  logic                           w_issue;
  logic [CNT_W:0]                 w_used;
  logic [CNT_W-1:0]               w_count_nxt;

  // Credit = queued entries plus the response still on its way back.
  assign w_used    = {1'b0, r_count} + (CNT_W + 1)'(r_inflight);
  assign w_issue   = npc_enn | (w_used < (CNT_W + 1)'(DEPTH));
  assign w_pop     = if_valid & ~stall & ~npc_enn;
  assign w_wr      = r_inflight & ~npc_enn;

  assign imem_en   = w_issue;
  assign imem_addr = npc_enn ? jump_target : r_fetch_pc;

  assign if_valid  = (r_count != '0);
  assign if_pc     = r_mem_pc[r_rd_ptr];
  assign if_inst   = r_mem_inst[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_wr && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= '0;
      r_inflight <= 1'b0;
      r_mem_pc   <= '0;
      r_mem_inst <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_fetch_pc <= imem_addr + PC_W'(1);
        r_resp_pc  <= imem_addr;
      end
      r_inflight <= w_issue;
      if (w_wr) begin
        r_mem_pc[r_wr_ptr]   <= r_resp_pc;
        r_mem_inst[r_wr_ptr] <= imem_rdata;
      end
      if (npc_enn) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_count <= w_count_nxt;
      end
    end
  end

endmodule
